// File: rtl/discrete_math_pkg.sv
// Shared fixed-point types, width helpers and saturation for the discrete-circuit math layer.
package discrete_math_pkg;

  localparam int FX_PRECISION = 24;
  localparam int FX_POINT     = 12;
  localparam int W            = FX_PRECISION + FX_POINT;
  localparam int WIDE         = 128;

  typedef logic signed [W-1:0]    fx_t;
  typedef logic signed [WIDE-1:0] wide_t;

  typedef enum logic [1:0] {IDLE, MAC, STORE, DONE} state_t;

  // Accumulator wide enough that SIZE shifted 2W-bit products never overflow.
  function automatic int acc_w(input int w, input int point, input int size);
    return 2 * w - point + $clog2(size) + 1;
  endfunction

  function automatic wide_t sat_w(input wide_t v, input int w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

  // |v| clamped to the positive full scale, so |-2^(w-1)| becomes 2^(w-1)-1.
  function automatic wide_t abs_sat(input wide_t v, input int w);
    wide_t hi;
    wide_t a;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    a  = (v < 0) ? -v : v;
    return (a > hi) ? hi : a;
  endfunction

endpackage

// File: rtl/fx_mac.sv
// Signed fixed-point multiply-accumulate: acc += (a*m) >>> POINT, with synchronous clear.
module fx_mac
  import discrete_math_pkg::*;
#(
  parameter int W     = 36,
  parameter int POINT = 12,
  parameter int SIZE  = 3
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   clear,
  input  logic                                   en,
  input  logic signed [W-1:0]                    a,
  input  logic signed [W-1:0]                    m,
  output logic signed [acc_w(W, POINT, SIZE)-1:0] acc
);

  localparam int ACC_W = acc_w(W, POINT, SIZE);

  logic signed [2*W-1:0]   prod;
  logic signed [2*W-1:0]   prod_sh;
  logic signed [ACC_W-1:0] term;

  // Arithmetic shift floors toward -inf; the dropped high bits are pure sign.
  assign prod    = a * m;
  assign prod_sh = prod >>> POINT;
  assign term    = ACC_W'(prod_sh);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        acc <= '0;
    else if (clear) acc <= '0;
    else if (en)    acc <= acc + term;
  end

endmodule

// File: rtl/jacobi_residual.sv
// Sequential y = A*x and r = b - y with max |r| and a converged flag against a tolerance.
module jacobi_residual
  import discrete_math_pkg::*;
#(
  parameter int     SIZE      = 3,
  parameter int     PRECISION = 24,
  parameter int     POINT     = 12,
  parameter longint TOLERANCE = 64'sd1 <<< 12
) (
  input  logic                                clk,
  input  logic                                I_RST,
  input  logic                                start,
  input  logic signed [PRECISION+POINT-1:0]   A [SIZE][SIZE],
  input  logic signed [PRECISION+POINT-1:0]   b [SIZE],
  input  logic signed [PRECISION+POINT-1:0]   x [SIZE],
  output logic signed [PRECISION+POINT-1:0]   y [SIZE],
  output logic signed [PRECISION+POINT-1:0]   r [SIZE],
  output logic        [PRECISION+POINT-1:0]   max_abs_r,
  output logic                                converged,
  output logic                                ready
);

  localparam int W     = PRECISION + POINT;
  localparam int ACC_W = acc_w(W, POINT, SIZE);
  localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(SIZE - 1);
  localparam logic [W-1:0]     TOL  = W'(TOLERANCE);

  state_t                  state, state_nx;
  logic [IDX_W-1:0]        row, col;
  logic                    mac_en, mac_clr;
  logic signed [ACC_W-1:0] acc;

  wide_t                   y_wide, r_wide;
  logic signed [W-1:0]     y_nx, r_nx;
  logic        [W-1:0]     abs_nx, max_nx;

  fx_mac #(.W(W), .POINT(POINT), .SIZE(SIZE)) u_mac (
    .clk   (clk),
    .rst   (I_RST),
    .clear (mac_clr),
    .en    (mac_en),
    .a     (A[row][col]),
    .m     (x[col]),
    .acc   (acc)
  );

  always_ff @(posedge clk or posedge I_RST) begin
    if (I_RST) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    mac_en   = 1'b0;
    mac_clr  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx = MAC;
          mac_clr  = 1'b1;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (col == LAST) state_nx = STORE;
      end
      STORE: begin
        mac_clr  = 1'b1;
        state_nx = (row == LAST) ? DONE : MAC;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Row result: the residual is taken against the already-saturated y.
  always_comb begin
    y_wide = sat_w(wide_t'(acc), W);
    y_nx   = W'(y_wide);
    r_wide = sat_w(wide_t'(b[row]) - y_wide, W);
    r_nx   = W'(r_wide);
    abs_nx = W'(abs_sat(r_wide, W));
    max_nx = (abs_nx > max_abs_r) ? abs_nx : max_abs_r;
  end

  always_ff @(posedge clk or posedge I_RST) begin
    if (I_RST) begin
      row       <= '0;
      col       <= '0;
      max_abs_r <= '0;
      converged <= 1'b0;
      ready     <= 1'b0;
      for (int i = 0; i < SIZE; i++) begin
        y[i] <= '0;
        r[i] <= '0;
      end
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            row       <= '0;
            col       <= '0;
            max_abs_r <= '0;
            converged <= 1'b0;
            ready     <= 1'b0;
          end
        end
        MAC: begin
          col <= (col == LAST) ? '0 : col + 1'b1;
        end
        STORE: begin
          y[row]    <= y_nx;
          r[row]    <= r_nx;
          max_abs_r <= max_nx;
          col       <= '0;
          if (row == LAST) begin
            ready     <= 1'b1;
            converged <= (max_nx <= TOL);
          end else begin
            row <= row + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
